// File: rtl/addsub_arb_pkg.sv
// Shared constants and state encoding for the shared add/sub arbiter.
package addsub_arb_pkg;
    localparam int   AS_W   = 4;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;
endpackage

// File: rtl/addsub4.sv
// 4-bit add/sub slice: op=1 computes x + ~y + 1; ovf is two's-complement overflow.
module addsub4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       op,
    output logic [3:0] sum,
    output logic       ovf
);
    logic [3:0] y_eff;

    assign y_eff = op ? ~y : y;
    assign sum   = x + y_eff + {3'b000, op};
    assign ovf   = (x[3] == y_eff[3]) && (sum[3] != x[3]);
endmodule

// File: rtl/rr_arbiter2.sv
// Combinational 2-way grant; prio names the winner when both requesters are valid.
module rr_arbiter2 (
    input  logic [1:0] req_valid,
    input  logic       prio,
    input  logic       en,
    output logic [1:0] grant,
    output logic       grant_id
);
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (en && (req_valid != 2'b00)) begin
            grant_id = (req_valid == 2'b11) ? prio : req_valid[1];
            grant    = grant_id ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/addsub_share_arbiter.sv
// Two requesters share one add/sub slice through a round-robin grant.
// Optional saturating statistics counters are enabled by ADDSUB_ARB_STATS_EN.
//
// state   | meaning
// IDLE    | waiting for a request; arbiter enabled
// EXEC    | slice evaluates latched operands
// RESP    | response held until rsp_ready
module addsub_share_arbiter
    import addsub_arb_pkg::*;
#(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [AS_W-1:0] req0_x,
    input  logic [AS_W-1:0] req0_y,
    input  logic            req0_op,
    input  logic [AS_W-1:0] req1_x,
    input  logic [AS_W-1:0] req1_y,
    input  logic            req1_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [AS_W-1:0] rsp_sum,
`ifdef ADDSUB_ARB_STATS_EN
    output logic [7:0]      ovf_count,
    output logic [7:0]      grant_count0,
    output logic [7:0]      grant_count1,
`endif
    output logic            rsp_ovf
);
    arb_state_t      state, state_nxt;
    logic            prio_ptr;
    logic [AS_W-1:0] op_x, op_y;
    logic            op_sub, op_id;
    logic [1:0]      grant;
    logic            grant_id;
    logic            arb_en;
    logic            accept;
    logic [AS_W-1:0] slice_sum;
    logic            slice_ovf;

    // Gating with rst_n keeps req_ready low during any reset cycle.
    assign arb_en = rst_n && (state == ST_IDLE);
    assign accept = (grant != 2'b00);

    rr_arbiter2 u_arb (
        .req_valid (req_valid),
        .prio      (prio_ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    assign req_ready = grant;

    addsub4 u_slice (
        .x   (op_x),
        .y   (op_y),
        .op  (op_sub),
        .sum (slice_sum),
        .ovf (slice_ovf)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_EXEC;
            ST_EXEC:                state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            prio_ptr  <= FIRST_PRIO;
            op_x      <= '0;
            op_y      <= '0;
            op_sub    <= OP_ADD;
            op_id     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_ovf   <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && accept) begin
                op_x     <= grant_id ? req1_x  : req0_x;
                op_y     <= grant_id ? req1_y  : req0_y;
                op_sub   <= grant_id ? req1_op : req0_op;
                op_id    <= grant_id;
                prio_ptr <= ~grant_id;
            end
            if (state == ST_EXEC) begin
                rsp_sum   <= slice_sum;
                rsp_ovf   <= slice_ovf;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            if (state == ST_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ADDSUB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_count    <= 8'd0;
            grant_count0 <= 8'd0;
            grant_count1 <= 8'd0;
        end else begin
            if (state == ST_EXEC && slice_ovf && ovf_count != 8'hFF)
                ovf_count <= ovf_count + 8'd1;
            if (grant[0] && grant_count0 != 8'hFF)
                grant_count0 <= grant_count0 + 8'd1;
            if (grant[1] && grant_count1 != 8'hFF)
                grant_count1 <= grant_count1 + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Scoreboard bench for addsub_share_arbiter: a driver predicts grants and results,
// a monitor drives rsp_ready and checks every response handshake.
`timescale 1ns/1ps
module tb_addsub_share_arbiter;
    localparam bit FIRST_PRIO = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid, req_ready;
    logic [3:0] req0_x, req0_y, req1_x, req1_y;
    logic       req0_op, req1_op;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_ovf;
    logic [3:0] rsp_sum;

    always #5 clk = ~clk;

    addsub_share_arbiter #(.FIRST_PRIO(FIRST_PRIO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_x    (req0_x),
        .req0_y    (req0_y),
        .req0_op   (req0_op),
        .req1_x    (req1_x),
        .req1_y    (req1_y),
        .req1_op   (req1_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ovf   (rsp_ovf)
    );

    typedef struct {
        logic       id;
        logic [3:0] sum;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_until = 0;
    int   grant_cyc = -100;
    int   grant_cnt = 0;
    logic last_g;
    logic       v[2];
    logic [3:0] mx[2], my[2];
    logic       mop[2];
    logic       rst_drv;
    int   bp_hold = 0;
    bit   rnd_ready = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: true signed arithmetic on the 4-bit two's-complement operands.
    function automatic exp_t ref_calc(logic id, logic [3:0] x, logic [3:0] y, logic op);
        int   sx, sy, r;
        exp_t e;
        sx = x[3] ? int'(x) - 16 : int'(x);
        sy = y[3] ? int'(y) - 16 : int'(y);
        r  = op ? sx - sy : sx + sy;
        e.id  = id;
        e.sum = r[3:0];
        e.ovf = (r > 7) || (r < -8);
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load(int r, logic [3:0] x, logic [3:0] y, logic op);
        v[r] = 1'b1; mx[r] = x; my[r] = y; mop[r] = op;
    endtask

    task automatic load_rand(int r);
        load(r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    // One cycle: apply requester state at negedge, then check the grant.
    task automatic step();
        logic [1:0] vv, exp_r;
        logic       g;
        bit         idle;
        @(negedge clk);
        rst_n     = rst_drv;
        vv        = {v[1], v[0]};
        req_valid = vv;
        req0_x = mx[0]; req0_y = my[0]; req0_op = mop[0];
        req1_x = mx[1]; req1_y = my[1]; req1_op = mop[1];
        #1;
        idle  = rst_drv && (cyc >= busy_until);
        exp_r = 2'b00;
        g     = 1'b0;
        if (idle && vv != 2'b00) begin
            g     = (vv == 2'b11) ? ~last_g : vv[1];
            exp_r = g ? 2'b10 : 2'b01;
        end
        chk("req_ready", req_ready, exp_r);
        if (exp_r != 2'b00) begin
            sb.push_back(ref_calc(g, mx[g], my[g], mop[g]));
            last_g     = g;
            busy_until = 32'h7FFF_FFFF;
            grant_cyc  = cyc;
            grant_cnt++;
            v[g]       = 1'b0;
        end
        if (rst_drv && cyc == grant_cyc + 1) chk("lat_exec_valid", rsp_valid, 0);
        if (rst_drv && cyc == grant_cyc + 2) chk("lat_resp_valid", rsp_valid, 1);
    endtask

    task automatic drain(int maxc);
        int n = 0;
        while ((v[0] || v[1] || cyc < busy_until || sb.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, queue %0d", maxc, sb.size());
        end
    endtask

    task automatic model_reset();
        sb.delete();
        busy_until = 0;
        grant_cyc  = -100;
        last_g     = ~FIRST_PRIO;
    endtask

    // Monitor: owns rsp_ready; pops and compares on each response handshake.
    initial begin
        exp_t       e;
        logic       stalled;
        logic       h_id, h_ovf;
        logic [3:0] h_sum;
        stalled   = 1'b0;
        h_id = 1'b0; h_ovf = 1'b0; h_sum = 4'd0;
        rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bp_hold > 0 && rsp_valid) begin
                rsp_ready = 1'b0;
                bp_hold--;
            end else if (rnd_ready) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                rsp_ready = 1'b1;
            end
            if (rst_n && rsp_valid) begin
                chk("req_ready_in_resp", req_ready, 0);
                if (stalled) begin
                    chk("hold_id", rsp_id, h_id);
                    chk("hold_sum", rsp_sum, h_sum);
                    chk("hold_ovf", rsp_ovf, h_ovf);
                end
                if (rsp_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL rsp_unexpected: id %0d sum %0d with nothing outstanding", rsp_id, rsp_sum);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_sum", rsp_sum, e.sum);
                        chk("rsp_ovf", rsp_ovf, e.ovf);
                    end
                    busy_until = cyc + 1;
                    stalled    = 1'b0;
                end else begin
                    stalled = 1'b1;
                    h_id = rsp_id; h_sum = rsp_sum; h_ovf = rsp_ovf;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n = 1'b0; req_valid = 2'b00; rst_drv = 1'b0;
        req0_x = 0; req0_y = 0; req0_op = 0; req1_x = 0; req1_y = 0; req1_op = 0;
        v[0] = 0; v[1] = 0;
        for (int r = 0; r < 2; r++) begin mx[r] = 0; my[r] = 0; mop[r] = 0; end
        model_reset();

        // Reset with both requesters already pending: no grant while rst_n is low.
        load_rand(0);
        load_rand(1);
        repeat (3) step();
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_sum", rsp_sum, 0);
        chk("reset_rsp_ovf", rsp_ovf, 0);
        chk("reset_rsp_id", rsp_id, 0);

        // Contention from reset, both held: grants alternate starting at FIRST_PRIO.
        rst_drv = 1'b1;
        guard = 0;
        while (grant_cnt < 8 && guard < 200) begin
            step();
            if (!v[0]) load_rand(0);
            if (!v[1]) load_rand(1);
            guard++;
        end
        v[0] = 0; v[1] = 0;
        drain(50);

        // Directed arithmetic cases.
        load(0, 4'd3, 4'd4, 1'b0); drain(50);
        load(1, 4'd7, 4'd1, 1'b0); drain(50);
        load(0, 4'd3, 4'd5, 1'b1); drain(50);
        load(0, 4'd8, 4'd1, 1'b1); drain(50);

        // Back-pressure for 5 cycles with the other requester waiting.
        bp_hold = 5;
        load(1, 4'd6, 4'd2, 1'b1);
        step();
        load(0, 4'd5, 4'd5, 1'b0);
        drain(60);

        // Reset while the transaction is in EXEC: it must vanish.
        load(0, 4'd9, 4'd3, 1'b0);
        guard = 0;
        while (v[0] && guard < 20) begin step(); guard++; end
        rst_drv = 1'b0;
        step();
        model_reset();
        rst_drv = 1'b1;
        step();
        chk("rst_exec_no_valid", rsp_valid, 0);
        step();
        chk("rst_exec_no_valid2", rsp_valid, 0);
        load_rand(0);
        load_rand(1);
        drain(60);

        // Randomised traffic with legal valid drops and random rsp_ready.
        rnd_ready = 1;
        for (int i = 0; i < 300; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!v[r] && $urandom_range(0, 1) == 1) load_rand(r);
                else if (v[r] && $urandom_range(0, 7) == 0) v[r] = 1'b0;
            end
            step();
        end
        v[0] = 0; v[1] = 0;
        drain(100);
        rnd_ready = 0;
        repeat (3) step();

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
